snoop_responder: RTL

Cache-side end of the coherence bus. The memory/coherence controller raises `ccwait` with `ccsnoopaddr` and `ccinv`. This block then looks up the owning dcache's tag and MSI state arrays and answers with `cctrans` and `ccwrite`. When the line is Modified, it flushes the 2-word block through `dstore`/`daddr`, gated by `dwait`. It finishes by writing back the next MSI state. One instance sits beside each dcache; the dcache FSM stalls while `snoop_active` is high.

---
 rtl/snoop_responder_if.sv | 35 +++
 rtl/snoop_responder.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/snoop_responder_if.sv
// Coherence-bus, dcache tag/state array and flush-port signals for one snoop_responder.
// The slave modport is the responder side; master is the controller/dcache side.
interface snoop_responder_if #(
  parameter int SETS = 8
);
  localparam int IW = $clog2(SETS);
  localparam int TW = 29 - IW;

  logic                     ccwait;
  logic [31:0]              ccsnoopaddr;
  logic                     ccinv;
  logic                     dwait;
  logic [IW-1:0]            snp_idx;
  logic [1:0][TW-1:0]       snp_tag;
  logic [1:0][1:0]          snp_state;
  logic [1:0][31:0]         snp_word;
  logic                     snp_way;
  logic                     st_we;
  logic [1:0]               st_next;
  logic                     cctrans;
  logic                     ccwrite;
  logic [31:0]              daddr;
  logic [31:0]              dstore;
  logic                     snoop_active;

  modport slave (
    input  ccwait, ccsnoopaddr, ccinv, dwait, snp_tag, snp_state, snp_word,
    output snp_idx, snp_way, st_we, st_next, cctrans, ccwrite, daddr, dstore, snoop_active
  );

  modport master (
    output ccwait, ccsnoopaddr, ccinv, dwait, snp_tag, snp_state, snp_word,
    input  snp_idx, snp_way, st_we, st_next, cctrans, ccwrite, daddr, dstore, snoop_active
  );
endinterface

// File: rtl/snoop_responder.sv
// Cache-side snoop responder: looks up tag/MSI state, answers the coherence controller,
// flushes a Modified 2-word block and writes back the next MSI state.
module snoop_responder #(
  parameter int SETS = 8,
  parameter int WAYS = 2
) (
  input  logic              CLK,
  input  logic              RST,
  snoop_responder_if.slave  bus
);
  localparam int IW = $clog2(SETS);
  localparam int TW = 29 - IW;

  localparam logic [1:0] ST_I = 2'b00;
  localparam logic [1:0] ST_S = 2'b01;
  localparam logic [1:0] ST_M = 2'b10;

  typedef enum logic [2:0] {
    IDLE, LOOKUP, FLUSH0, FLUSH1, RESP, UPDATE, DONE
  } state_e;

  state_e       state_q, state_d;
  logic [28:0]  blk_q, blk_d;
  logic         inv_q, inv_d;
  logic         hit_q, hit_d;
  logic         way_q, way_d;
  logic         cctrans_q, cctrans_d;
  logic         ccwrite_q, ccwrite_d;
  logic         st_we_q, st_we_d;
  logic [1:0]   st_next_q, st_next_d;
  logic         active_q, active_d;
  logic [31:0]  daddr_q, daddr_d;

  // Byte/word offset never matters: the whole block is flushed from its base.
  logic unused_offset;
  assign unused_offset = ^bus.ccsnoopaddr[2:0];

  logic [TW-1:0]   addr_tag;
  logic [WAYS-1:0] way_hit;
  logic            look_hit;
  logic            hit_way;
  logic            hit_m;

  assign addr_tag = blk_q[28:IW];

  for (genvar w = 0; w < WAYS; w++) begin : g_way
    assign way_hit[w] = (bus.snp_tag[w] == addr_tag) && (bus.snp_state[w] != ST_I);
  end

  // Way0 wins when both ways match.
  assign look_hit = |way_hit;
  assign hit_way  = ~way_hit[0];
  assign hit_m    = look_hit && (bus.snp_state[hit_way] == ST_M);

  always_comb begin
    state_d = state_q;
    blk_d   = blk_q;
    inv_d   = inv_q;
    hit_d   = hit_q;
    way_d   = way_q;
    case (state_q)
      IDLE: begin
        if (bus.ccwait) begin
          blk_d   = bus.ccsnoopaddr[31:3];
          inv_d   = bus.ccinv;
          state_d = LOOKUP;
        end
      end
      LOOKUP: begin
        if (!bus.ccwait) begin
          state_d = IDLE;
        end else begin
          hit_d   = look_hit;
          way_d   = look_hit ? hit_way : 1'b0;
          state_d = hit_m ? FLUSH0 : RESP;
        end
      end
      // A dropped ccwait is ignored here so memory never sees a torn block.
      FLUSH0: if (!bus.dwait) state_d = FLUSH1;
      FLUSH1: if (!bus.dwait) state_d = UPDATE;
      RESP: begin
        if (!bus.ccwait)    state_d = IDLE;
        else if (hit_q)     state_d = UPDATE;
        else                state_d = DONE;
      end
      UPDATE: state_d = DONE;
      DONE:   if (!bus.ccwait) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    cctrans_d = state_d inside {FLUSH0, FLUSH1, RESP};
    ccwrite_d = state_d inside {FLUSH0, FLUSH1};
    st_we_d   = (state_d == UPDATE);
    st_next_d = (state_d == UPDATE) ? (inv_d ? ST_I : ST_S) : ST_I;
    active_d  = (state_d != IDLE);
    case (state_d)
      FLUSH0:  daddr_d = {blk_d, 3'b000};
      FLUSH1:  daddr_d = {blk_d, 3'b100};
      default: daddr_d = '0;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= IDLE;
      blk_q     <= '0;
      inv_q     <= 1'b0;
      hit_q     <= 1'b0;
      way_q     <= 1'b0;
      cctrans_q <= 1'b0;
      ccwrite_q <= 1'b0;
      st_we_q   <= 1'b0;
      st_next_q <= ST_I;
      active_q  <= 1'b0;
      daddr_q   <= '0;
    end else begin
      state_q   <= state_d;
      blk_q     <= blk_d;
      inv_q     <= inv_d;
      hit_q     <= hit_d;
      way_q     <= way_d;
      cctrans_q <= cctrans_d;
      ccwrite_q <= ccwrite_d;
      st_we_q   <= st_we_d;
      st_next_q <= st_next_d;
      active_q  <= active_d;
      daddr_q   <= daddr_d;
    end
  end

  assign bus.snp_idx      = blk_q[IW-1:0];
  assign bus.snp_way      = way_q;
  assign bus.st_we        = st_we_q;
  assign bus.st_next      = st_next_q;
  assign bus.cctrans      = cctrans_q;
  assign bus.ccwrite      = ccwrite_q;
  assign bus.daddr        = daddr_q;
  assign bus.snoop_active = active_q;

  // Data array read is combinational on (snp_idx, snp_way), both already settled in flush states.
  assign bus.dstore = (state_q == FLUSH0) ? bus.snp_word[0] :
                      (state_q == FLUSH1) ? bus.snp_word[1] : '0;
endmodule
